ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch front end for the LC-3b pipeline. It issues sequential reads to the instruction memory port and buffers the returned words in a small FIFO. It presents `inst`/`pc` pairs, with a valid/stall handshake, to the decode stage that builds the instruction packet. Control-transfer redirects from later stages flush the buffer and restart fetch at the new target, including dropping a response that is still in flight.

## Interface
- `RESET_PC`, 16'h0000, first fetch address after reset.
- `FIFO_DEPTH`, 2, number of buffered instructions; legal values are 2 to 8, powers of two only.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_address`  out  16  fetch address; held stable while `imem_read` is high and `imem_resp` is low.
- `imem_read`  out  1  read request.
- `imem_resp`  in  1  one-cycle response strobe; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  16  returned instruction word.
- `inst`  out  16  instruction to decode; 16'h0000 (BR nzp=000, a NOP) when `inst_valid` is low.
- `pc`  out  16  address of `inst` (decode adds 2); 16'h0000 when `inst_valid` is low.
- `inst_valid`  out  1  `inst`/`pc` are meaningful.
- `stall`  in  1  decode not ready; a pair is consumed when `inst_valid && !stall`.
- `redirect`  in  1  one-cycle flush-and-restart strobe.
- `redirect_target`  in  16  new fetch address; bit 0 is ignored and forced to 0.

## Operation
- Registers:
  - `fetch_pc`: 16-bit, always even.
  - FIFO of {inst, pc}: `count` holds 0..FIFO_DEPTH, with read and write pointers that wrap modulo FIFO_DEPTH.
  - state: FETCH, WAIT_SPACE, DISCARD.
- FETCH:
  - `imem_read`=1, `imem_address`=`fetch_pc`.
  - On `imem_resp`: push {`imem_rdata`, `fetch_pc`}, then `fetch_pc`+=2 (16-bit wrap, so 16'hFFFE goes to 16'h0000).
  - After the push, stay in FETCH if `count` is below FIFO_DEPTH; otherwise go to WAIT_SPACE.
- WAIT_SPACE:
  - `imem_read`=0.
  - Return to FETCH in the cycle after `count` drops below FIFO_DEPTH.
- DISCARD:
  - `imem_read`=1 with the old address, held until `imem_resp`.
  - The response data is dropped and not pushed.
  - Then go to FETCH at the stored redirect target.
- Output side:
  - `inst_valid` = (`count`!=0).
  - `inst`/`pc` come from the FIFO head (combinational read).
  - A pop occurs when `inst_valid && !stall`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Redirect has priority over every other event in the same cycle:
  - FIFO cleared (`count`=0) and `fetch_pc`=target.
  - A pop in that cycle still counts as a consume by decode.
  - If the state is FETCH with no `imem_resp` that cycle, go to DISCARD.
  - If the state is FETCH with `imem_resp` that cycle, drop the data and stay in FETCH at the target.
  - In WAIT_SPACE, go to FETCH.
  - In DISCARD, stay in DISCARD with the target updated (the last redirect wins).
- A response received in FETCH is never lost. The FETCH entry condition guarantees a free slot, because at most one request is outstanding.

## Timing
- Reset (asynchronous, applies immediately):
  - state=FETCH, `fetch_pc`=RESET_PC, `count`=0, pointers=0.
  - Outputs: `imem_read`=0, `imem_address`=RESET_PC, `inst`=0, `pc`=0, `inst_valid`=0.
- `imem_read` is gated low while `reset_n` is low. It rises in the first clock edge's cycle after release.
- Without bypass, a response in cycle N gives `inst_valid` in cycle N+1.
- Back-to-back hits (`imem_resp` every cycle) sustain 1 instruction per cycle with no stall.
- A new address is presented in the cycle after each response. `imem_read` stays high across the address change.
- After a redirect, `inst_valid`=0 from the next cycle until the first response from the target.
- Reset asserted mid-request abandons the request; the memory side must tolerate this.

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - If `count`==0 and `stall`==0 in a response cycle, `imem_rdata` and `fetch_pc` drive `inst`/`pc` with `inst_valid`=1 in that same cycle, and the entry is not pushed.
  - A stalled response is pushed as normal.
  - Bypass is suppressed in any cycle where `redirect`=1.
- `IFETCH_BYPASS_EN` undefined: every instruction passes through the FIFO, giving a fixed one-cycle response-to-valid latency.

## Test plan
- Reset release, then `imem_resp` every cycle with the data equal to the address. Required: `imem_address` steps 0000, 0002, 0004…; `inst`/`pc` pairs are (0000,0000), (0002,0002)… in order, with no gaps.
- Hold `stall`=1 with FIFO_DEPTH=2. Required:
  - Exactly 2 responses are accepted, then `imem_read`=0 (WAIT_SPACE).
  - Release `stall`: `imem_read` rises one cycle after the first pop, and the order is preserved.
- Redirect to 16'h3000 while a request to 16'h0004 is pending, with the response arriving 3 cycles later. Required:
  - `imem_address` holds 0004 until the response, and that data is dropped.
  - The next request is 3000, and the next valid `pc` is 3000.
- Redirect to 16'h1000 in the same cycle as `imem_resp` and a pop. Required: the FIFO is empty next cycle and the next request is 1000.
- `fetch_pc`=16'hFFFE with hits. Required: the next address wraps to 0000.
- With `IFETCH_BYPASS_EN`: empty FIFO, `stall`=0, response 16'h1234 at address 0040. Required: `inst`=1234, `pc`=0040, `inst_valid`=1 in the same cycle, and `count` stays 0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: sequential imem reads buffered in a small {inst, pc} FIFO,
// with redirect flush/discard. Define IFETCH_BYPASS_EN to forward a response straight to decode.
module ifetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] imem_address,
    output logic        imem_read,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    output logic [15:0] inst,
    output logic [15:0] pc,
    output logic        inst_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_target
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {FETCH, WAIT_SPACE, DISCARD} state_t;

    state_t        state, state_next;
    logic [15:0]   fetch_pc, fetch_pc_next;
    logic [15:0]   discard_addr, discard_addr_next;
    logic [15:0]   fifo_inst [FIFO_DEPTH];
    logic [15:0]   fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic [15:0]   target;
    logic          resp_hit, bypass_hit, push, pop, full_next;

    assign target   = redirect_target & 16'hFFFE;
    assign resp_hit = reset_n && (state == FETCH) && imem_resp;

`ifdef IFETCH_BYPASS_EN
    assign bypass_hit = resp_hit && !redirect && (count == '0) && !stall;
`else
    assign bypass_hit = 1'b0;
`endif

    // A redirect drops any response that lands in the same cycle.
    assign push = resp_hit && !redirect && !bypass_hit;
    assign pop  = (count != '0) && !stall;

    always_comb begin
        count_next = count;
        if (redirect)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CW'(1);
        else if (!push && pop)
            count_next = count - CW'(1);
    end

    assign full_next = (count_next == CW'(FIFO_DEPTH));

    always_comb begin
        state_next        = state;
        fetch_pc_next     = fetch_pc;
        discard_addr_next = discard_addr;
        case (state)
            FETCH: begin
                if (redirect) begin
                    fetch_pc_next = target;
                    if (!imem_resp) begin
                        state_next        = DISCARD;
                        discard_addr_next = fetch_pc;
                    end
                end else if (imem_resp) begin
                    fetch_pc_next = fetch_pc + 16'd2;
                    if (full_next)
                        state_next = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (redirect) begin
                    state_next    = FETCH;
                    fetch_pc_next = target;
                end else if (!full_next) begin
                    state_next = FETCH;
                end
            end
            DISCARD: begin
                // The old request stays on the bus until memory answers it.
                if (redirect)
                    fetch_pc_next = target;
                else if (imem_resp)
                    state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FETCH;
            fetch_pc     <= RESET_PC;
            discard_addr <= RESET_PC;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
        end else begin
            state        <= state_next;
            fetch_pc     <= fetch_pc_next;
            discard_addr <= discard_addr_next;
            count        <= count_next;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= fetch_pc;
        end
    end

    always_comb begin
        inst       = 16'h0000;
        pc         = 16'h0000;
        inst_valid = 1'b0;
        if (count != '0) begin
            inst_valid = 1'b1;
            inst       = fifo_inst[rd_ptr];
            pc         = fifo_pc[rd_ptr];
        end else if (bypass_hit) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            pc         = fetch_pc;
        end
    end

    assign imem_read    = reset_n && (state != WAIT_SPACE);
    assign imem_address = (state == DISCARD) ? discard_addr : fetch_pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized run checked
// against a queue-based reference model of the fetch buffer.
module tb_ifetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] imem_address;
    logic        imem_read;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic [15:0] inst;
    logic [15:0] pc;
    logic        inst_valid;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_target;

    int checks = 0;
    int passed = 0;

    // Reference model: buffered {inst, pc} pairs plus the next fetch address.
    logic [31:0] q[$];
    logic [15:0] mpc;
    logic [15:0] old_addr;
    bit          waiting;
    bit          discarding;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(16'h0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_address(imem_address), .imem_read(imem_read),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .inst(inst), .pc(pc), .inst_valid(inst_valid),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target)
    );

    function automatic bit model_reading();
        return discarding || !waiting;
    endfunction

    task automatic model_reset();
        q.delete();
        mpc        = 16'h0000;
        old_addr   = 16'h0000;
        waiting    = 0;
        discarding = 0;
    endtask

    function automatic void predict(output logic er, output logic [15:0] ea, output logic ev,
                                    output logic [15:0] ei, output logic [15:0] ep);
        bit byp;
        byp = 0;
        er  = model_reading();
        ea  = discarding ? old_addr : mpc;
`ifdef IFETCH_BYPASS_EN
        byp = imem_resp && !discarding && !waiting && (q.size() == 0) && !stall && !redirect;
`endif
        ev = 1'b0; ei = 16'h0000; ep = 16'h0000;
        if (q.size() != 0) begin
            ev = 1'b1; ei = q[0][31:16]; ep = q[0][15:0];
        end else if (byp) begin
            ev = 1'b1; ei = imem_rdata; ep = mpc;
        end
    endfunction

    task automatic drive(input bit r, input logic [15:0] d, input bit s, input bit rd,
                         input logic [15:0] t);
        imem_resp = r; imem_rdata = d; stall = s; redirect = rd; redirect_target = t;
        #2;
    endtask

    // Apply the current inputs to the model, then move to just after the next edge.
    task automatic advance();
        bit          consumed;
        bit          byp;
        logic [31:0] dummy;
        logic [15:0] tgt;
        tgt      = {redirect_target[15:1], 1'b0};
        consumed = (q.size() > 0) && !stall;
        byp      = 0;
`ifdef IFETCH_BYPASS_EN
        byp = imem_resp && !discarding && !waiting && (q.size() == 0) && !stall && !redirect;
`endif
        if (redirect) begin
            q.delete();
            if (discarding)       mpc = tgt;
            else if (waiting)     begin waiting = 0; mpc = tgt; end
            else if (imem_resp)   mpc = tgt;
            else                  begin discarding = 1; old_addr = mpc; mpc = tgt; end
        end else if (discarding) begin
            if (imem_resp) discarding = 0;
        end else if (waiting) begin
            if (consumed) begin dummy = q.pop_front(); waiting = 0; end
        end else begin
            if (consumed) dummy = q.pop_front();
            if (imem_resp) begin
                if (!byp) q.push_back({imem_rdata, mpc});
                mpc = mpc + 16'd2;
                if (q.size() == DEPTH) waiting = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 16'h0000, 0, 0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_read !== 1'b0) $display("[TB] FAIL reset_read got %b want 0", imem_read); else passed++;
        checks++; if (imem_address !== 16'h0000) $display("[TB] FAIL reset_addr got %h want 0000", imem_address); else passed++;
        checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", inst_valid); else passed++;
        checks++; if (inst !== 16'h0000 || pc !== 16'h0000)
            $display("[TB] FAIL reset_pair got %h/%h want 0000/0000", inst, pc); else passed++;
        model_reset();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (imem_read !== 1'b1) $display("[TB] FAIL release_read got %b want 1", imem_read); else passed++;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 10; k++) begin
            logic [15:0] a;
            logic [15:0] p;
            a = 16'(2 * k);
            p = 16'(2 * (k - 1));
            drive(1, a, 0, 0, 16'h0000);
            checks++; if (imem_address !== a) $display("[TB] FAIL seq_addr got %h want %h", imem_address, a); else passed++;
            if (k == 0) begin
                checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL seq_first_valid got %b want 0", inst_valid); else passed++;
            end else begin
                checks++; if (inst_valid !== 1'b1 || inst !== p || pc !== p)
                    $display("[TB] FAIL seq_pair got %b %h/%h want 1 %h/%h", inst_valid, inst, pc, p, p); else passed++;
            end
            advance();
        end
    endtask

    task automatic test_stall_full();
        int accepted;
        accepted = 0;
        drive(1, 16'h1111, 1, 1, 16'h0200);
        advance();
        for (int k = 0; k < 6; k++) begin
            logic er;
            er = model_reading();
            drive(er, mpc ^ 16'h5A00, 1, 0, 16'h0000);
            checks++; if (imem_read !== er) $display("[TB] FAIL stall_read got %b want %b", imem_read, er); else passed++;
            if (imem_read === 1'b1) accepted++;
            advance();
        end
        checks++; if (accepted != 2) $display("[TB] FAIL stall_accepted got %0d want 2", accepted); else passed++;
        drive(0, 16'h0000, 0, 0, 16'h0000);
        checks++; if (imem_read !== 1'b0 || pc !== 16'h0200 || inst !== (16'h0200 ^ 16'h5A00))
            $display("[TB] FAIL stall_pop1 got read=%b pc=%h inst=%h want 0 0200 %h", imem_read, pc, inst, 16'h0200 ^ 16'h5A00); else passed++;
        advance();
        drive(1, 16'h0204 ^ 16'h5A00, 0, 0, 16'h0000);
        checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0204 || pc !== 16'h0202)
            $display("[TB] FAIL stall_resume got read=%b addr=%h pc=%h want 1 0204 0202", imem_read, imem_address, pc); else passed++;
        advance();
        drive(0, 16'h0000, 0, 0, 16'h0000);
        checks++; if (inst_valid !== 1'b1 || pc !== 16'h0204)
            $display("[TB] FAIL stall_order got %b %h want 1 0204", inst_valid, pc); else passed++;
        advance();
    endtask

    task automatic test_redirect_pending();
        drive(1, 16'h0000, 0, 1, 16'h0000);
        advance();
        drive(1, 16'h0000, 0, 0, 16'h0000); advance();
        drive(1, 16'h0002, 0, 0, 16'h0000); advance();
        drive(0, 16'h0000, 0, 1, 16'h3000);
        checks++; if (imem_address !== 16'h0004) $display("[TB] FAIL redir_addr0 got %h want 0004", imem_address); else passed++;
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(k == 2, 16'hBEEF, 0, 0, 16'h0000);
            checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0004 || inst_valid !== 1'b0)
                $display("[TB] FAIL redir_hold got read=%b addr=%h valid=%b want 1 0004 0", imem_read, imem_address, inst_valid); else passed++;
            advance();
        end
        drive(1, 16'h7777, 0, 0, 16'h0000);
        checks++; if (imem_address !== 16'h3000 || inst_valid !== 1'b0)
            $display("[TB] FAIL redir_new got addr=%h valid=%b want 3000 0", imem_address, inst_valid); else passed++;
        advance();
        drive(0, 16'h0000, 0, 0, 16'h0000);
        checks++; if (inst_valid !== 1'b1 || pc !== 16'h3000 || inst !== 16'h7777)
            $display("[TB] FAIL redir_first got %b %h/%h want 1 7777/3000", inst_valid, inst, pc); else passed++;
        advance();
    endtask

    task automatic test_redirect_resp_pop();
        drive(1, 16'hAAAA, 0, 0, 16'h0000); advance();
        drive(1, 16'hBBBB, 0, 1, 16'h1001);
        checks++; if (inst_valid !== 1'b1 || pc !== 16'h3002)
            $display("[TB] FAIL rrp_pop got %b %h want 1 3002", inst_valid, pc); else passed++;
        advance();
        drive(0, 16'h0000, 0, 0, 16'h0000);
        checks++; if (inst_valid !== 1'b0 || imem_read !== 1'b1 || imem_address !== 16'h1000)
            $display("[TB] FAIL rrp_after got valid=%b read=%b addr=%h want 0 1 1000", inst_valid, imem_read, imem_address); else passed++;
        advance();
        drive(1, 16'hCCCC, 0, 0, 16'h0000); advance();
        drive(0, 16'h0000, 0, 0, 16'h0000);
        checks++; if (inst_valid !== 1'b1 || pc !== 16'h1000 || inst !== 16'hCCCC)
            $display("[TB] FAIL rrp_first got %b %h/%h want 1 CCCC/1000", inst_valid, inst, pc); else passed++;
        advance();
    endtask

    task automatic test_wrap();
        drive(1, 16'h0000, 0, 1, 16'hFFFC);
        advance();
        for (int k = 0; k < 4; k++) begin
            logic [15:0] a;
            a = 16'hFFFC + 16'(2 * k);
            drive(1, a ^ 16'h0F0F, 0, 0, 16'h0000);
            checks++; if (imem_address !== a) $display("[TB] FAIL wrap_addr got %h want %h", imem_address, a); else passed++;
            advance();
        end
    endtask

    task automatic test_random();
        logic        er, ev;
        logic [15:0] ea, ei, ep;
        int          bad;
        bad = 0;
        for (int k = 0; k < 400; k++) begin
            drive(model_reading() && ($urandom_range(0, 3) != 0), 16'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 16'($urandom));
            predict(er, ea, ev, ei, ep);
            checks++;
            if (imem_read !== er || (er && imem_address !== ea) || inst_valid !== ev || inst !== ei || pc !== ep) begin
                if (bad < 10)
                    $display("[TB] FAIL rand_cycle%0d got read=%b addr=%h v=%b %h/%h want %b %h %b %h/%h",
                             k, imem_read, imem_address, inst_valid, inst, pc, er, ea, ev, ei, ep);
                bad++;
            end else begin
                passed++;
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        drive(0, 16'h0000, 1, 0, 16'h0000);
        reset_n = 1'b0;
        #1;
        checks++; if (imem_read !== 1'b0 || imem_address !== 16'h0000 || inst_valid !== 1'b0 || inst !== 16'h0000 || pc !== 16'h0000)
            $display("[TB] FAIL async_reset got read=%b addr=%h v=%b %h/%h want 0 0000 0 0000/0000",
                     imem_read, imem_address, inst_valid, inst, pc); else passed++;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0000)
            $display("[TB] FAIL async_release got read=%b addr=%h want 1 0000", imem_read, imem_address); else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_full();
        test_redirect_pending();
        test_redirect_resp_pop();
        test_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
